// File: rtl/writeback_unit.sv
// Writeback scheduler: owns the single register-file write port.
// ALU and load results are queued in order, drained one per cycle into the
// registered write port, and every in-flight result can be forwarded to decode.
module writeback_unit #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_word,
   output logic        write_signal,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data,
   input  logic [4:0]  fwd_rs1,
   input  logic [4:0]  fwd_rs2,
   output logic        fwd1_hit,
   output logic        fwd2_hit,
   output logic [31:0] fwd1_data,
   output logic [31:0] fwd2_data,
   output logic        busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_M1_C = CW'(FIFO_DEPTH - 1);

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    entry_rd_q   [FIFO_DEPTH];
   logic [4:0]    entry_rd_d   [FIFO_DEPTH];
   logic [31:0]   entry_data_q [FIFO_DEPTH];
   logic [31:0]   entry_data_d [FIFO_DEPTH];
   logic          write_signal_q, write_signal_d;
   logic [4:0]    write_reg_q, write_reg_d;
   logic [31:0]   write_data_q, write_data_d;

   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_ext;
   logic          ld_push;
   logic          alu_push;
   logic          pop;
   logic [PW-1:0] alu_slot;
   logic [PW-1:0] fwd_idx;

   assign write_signal = write_signal_q;
   assign write_reg    = write_reg_q;
   assign write_data   = write_data_q;
   assign busy         = (count_q != '0) || write_signal_q;

   // Acceptance looks only at the registered count; a load reserves its slot
   // before the ALU so that with one slot left the load wins.
   always_comb begin
      ld_ready  = !rst && (count_q < DEPTH_C);
      alu_ready = !rst && (ld_valid ? (count_q < DEPTH_M1_C) : (count_q < DEPTH_C));
   end

   // Pick the addressed byte/half-word from the aligned load word and extend it.
   always_comb begin
      ld_byte = 8'h00;
      case (ld_addr_lo)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_funct3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = ld_word;
      endcase
   end

   // Next-state: pop the head into the write port, then enqueue load before ALU;
   // x0 results finish their handshake but never take a slot.
   always_comb begin
      ld_push        = ld_valid && ld_ready && (ld_rd != 5'd0);
      alu_push       = alu_valid && alu_ready && (alu_rd != 5'd0);
      pop            = (count_q != '0);
      head_d         = head_q;
      entry_rd_d     = entry_rd_q;
      entry_data_d   = entry_data_q;
      write_signal_d = 1'b0;
      write_reg_d    = write_reg_q;
      write_data_d   = write_data_q;
      if (pop) begin
         write_signal_d = 1'b1;
         write_reg_d    = entry_rd_q[head_q];
         write_data_d   = entry_data_q[head_q];
         head_d         = head_q + PW'(1);
      end
      if (ld_push) begin
         entry_rd_d[tail_q]   = ld_rd;
         entry_data_d[tail_q] = ld_ext;
      end
      alu_slot = ld_push ? (tail_q + PW'(1)) : tail_q;
      if (alu_push) begin
         entry_rd_d[alu_slot]   = alu_rd;
         entry_data_d[alu_slot] = alu_data;
      end
      tail_d  = tail_q + PW'(ld_push) + PW'(alu_push);
      count_d = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
   end

   // State registers; reset throws away every queued entry and the pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         write_signal_q <= 1'b0;
         write_reg_q    <= 5'd0;
         write_data_q   <= 32'd0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         write_signal_q <= write_signal_d;
         write_reg_q    <= write_reg_d;
         write_data_q   <= write_data_d;
         entry_rd_q     <= entry_rd_d;
         entry_data_q   <= entry_data_d;
      end
   end

   // Forwarding scans oldest to youngest so later matches overwrite earlier ones;
   // the output register is oldest because the register file commits after it.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = 32'd0;
      fwd2_hit  = 1'b0;
      fwd2_data = 32'd0;
      fwd_idx   = '0;
      if (write_signal_q && (write_reg_q == fwd_rs1)) begin
         fwd1_hit  = 1'b1;
         fwd1_data = write_data_q;
      end
      if (write_signal_q && (write_reg_q == fwd_rs2)) begin
         fwd2_hit  = 1'b1;
         fwd2_data = write_data_q;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (CW'(i) < count_q) begin
            fwd_idx = head_q + PW'(i);
            if (entry_rd_q[fwd_idx] == fwd_rs1) begin
               fwd1_hit  = 1'b1;
               fwd1_data = entry_data_q[fwd_idx];
            end
            if (entry_rd_q[fwd_idx] == fwd_rs2) begin
               fwd2_hit  = 1'b1;
               fwd2_data = entry_data_q[fwd_idx];
            end
         end
      end
      if (fwd_rs1 == 5'd0) begin
         fwd1_hit  = 1'b0;
         fwd1_data = 32'd0;
      end
      if (fwd_rs2 == 5'd0) begin
         fwd2_hit  = 1'b0;
         fwd2_data = 32'd0;
      end
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback scheduler that owns the single register-file write port in the pipelined core. It accepts results from the ALU path and the load path through valid/ready handshakes. Load data is byte/half-word extracted and extended before queuing. Results are held in a small in-order FIFO, and the block drives one register write per cycle. It also provides a forwarding lookup over all in-flight results, so decode never reads a stale register.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of queued results; power of two, ≥2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- alu_valid  input  1  ALU result present
- alu_ready  output  1  ALU result accepted this cycle when alu_valid high
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- ld_valid  input  1  load result present
- ld_ready  output  1  load result accepted this cycle when ld_valid high
- ld_rd  input  5  load destination register
- ld_funct3  input  3  load type (RISC-V funct3)
- ld_addr_lo  input  2  load address bits [1:0]
- ld_word  input  32  aligned 32-bit memory word
- write_signal  output  1  register-file write enable (registered)
- write_reg  output  5  register-file write address (registered)
- write_data  output  32  register-file write data (registered)
- fwd_rs1, fwd_rs2  input  5 each  source registers to look up
- fwd1_hit, fwd2_hit  output  1 each  pending value exists for rs1/rs2
- fwd1_data, fwd2_data  output  32 each  youngest pending value
- busy  output  1  FIFO non-empty or write_signal high

## Operation
Queue and acceptance:
- Circular FIFO with head and tail pointers and a count register (0..FIFO_DEPTH).
- ld_ready = !rst && count < FIFO_DEPTH.
- alu_ready = !rst && count < FIFO_DEPTH − (ld_valid ? 1 : 0).
- Ready is computed from the registered count only. It takes no credit for a same-cycle pop.
- When both sources are accepted in the same cycle, the load entry is enqueued first (older) and the ALU entry second.
- A result with rd = 0 completes its handshake but is not enqueued. It is never written and never forwarded.

Load extraction, applied before enqueue:
- 000 LB: ld_word[8·addr_lo +: 8], sign-extended.
- 100 LBU: the same byte, zero-extended.
- 001 LH: addr_lo[1] selects ld_word[31:16] or ld_word[15:0], sign-extended. addr_lo[0] is ignored.
- 101 LHU: the same half-word, zero-extended.
- 010 LW and all other codes: ld_word unchanged.

Drain:
- If count > 0, the head entry is popped every cycle into the output register, and write_signal is 1 in the next cycle.
- If count = 0, write_signal is 0 in the next cycle.
- Writes leave strictly in enqueue order.

Forwarding:
- Candidates are all valid FIFO entries plus the output register (when write_signal = 1).
- The youngest match wins: the newest FIFO entry first, then older entries, then the output register.
- hit = 0 and data = 0 when rs = 0 or there is no match.
- The output register is included because the register file only commits at the edge ending the write cycle.

Reset:
- While rst is high, both ready outputs are 0.
- At the edge with rst high: count = 0, pointers = 0, write_signal = 0, write_reg = 0, write_data = 0.
- Reset mid-operation discards every pending entry. No write occurs in the cycle after reset.

Simultaneous events:
- A push and a pop in the same cycle leave count += pushes − 1.
- With one free slot and both sources valid, the load is accepted and alu_ready = 0.

## Timing
- Accept edge E, with the FIFO empty: the entry is at the head in cycle E+1, and write_signal/write_reg/write_data are valid in cycle E+2. Latency is 2 cycles.
- With an occupied FIFO, latency is 2 + (entries ahead).
- Throughput is one register write per cycle, sustained.
- The ready outputs are combinational from count and ld_valid.
- The fwd outputs are combinational from fwd_rs* and registered state, with no path from the source inputs.
- Accepted data appears in the forwarding result from cycle E+1.

## Test plan
- Single ALU result: alu_rd = 5, alu_data = 0xDEADBEEF, accepted in cycle 0 → write_signal = 1, write_reg = 5, write_data = 0xDEADBEEF in cycle 2 only. fwd_rs1 = 5 hits in cycles 1–2.
- Load extension, with ld_word = 0x8812F07F:
  - LB, addr_lo = 0 → 0x0000007F.
  - LB, addr_lo = 1 → 0xFFFFFFF0.
  - LBU, addr_lo = 3 → 0x00000088.
  - LH, addr_lo = 2 → 0xFFFF8812.
  - LHU, addr_lo = 0 → 0x0000F07F.
  - LW → 0x8812F07F.
- Simultaneous accept, with the FIFO empty: load rd = 3 and ALU rd = 4 → writes to x3 then x4 in consecutive cycles 2 and 3.
- Fill to 4 with ALU results, then present load and ALU together: ld_ready = 1, alu_ready = 0 at count = 3. Both readies = 0 at count = 4. No entry is lost, and all 4 writes drain in order.
- Two pending writes to x7 (0x1 older, 0x2 younger) → fwd1_data = 0x2. After the younger drains through the output register, the hit clears. rd = 0 input → no write and no hit.
- Assert rst for 1 cycle with 3 entries queued → all outputs zero, no write_signal afterwards, busy = 0, readies = 1 after release.
